// File: rtl/imem_port_arbiter_if.sv
// Handshake bundle between the fetch port, the debug port and the shared imem
// read port. slave = arbiter side, master = requesters/ROM side.
interface imem_port_arbiter_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
);
  logic          f_req_valid;
  logic [AW-1:0] f_req_addr;
  logic          f_req_ready;
  logic          f_rsp_valid;
  logic [DW-1:0] f_rsp_data;
  logic [AW-1:0] f_rsp_addr;
  logic          f_rsp_ready;

  logic          d_req_valid;
  logic [AW-1:0] d_req_addr;
  logic          d_req_ready;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic [AW-1:0] d_rsp_addr;
  logic          d_rsp_ready;

  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_q;
  logic          busy;

  modport slave (
    input  f_req_valid, f_req_addr, f_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    input  imem_q,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_addr,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_addr,
    output imem_addr, busy
  );

  modport master (
    output f_req_valid, f_req_addr, f_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    output imem_q,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_addr,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_addr,
    input  imem_addr, busy
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter for the combinational instruction ROM: fetch has priority,
// debug gets a forced grant after MAX_WAIT consecutive lost cycles.
module imem_port_arbiter #(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic               clk,
  input logic               reset,
  imem_port_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic          f_elig, d_elig;
  logic          grant_f, grant_d;
  logic [AW-1:0] gnt_addr;

  logic [3:0]    wait_q, wait_d;
  logic [AW-1:0] last_addr_q, last_addr_d;

  logic          f_vld_q, f_vld_d;
  logic [DW-1:0] f_data_q, f_data_d;
  logic [AW-1:0] f_addr_q, f_addr_d;
  logic          d_vld_q, d_vld_d;
  logic [DW-1:0] d_data_q, d_data_d;
  logic [AW-1:0] d_addr_q, d_addr_d;

  // Gating eligibility with reset keeps ready/busy/imem_addr at 0 during reset.
  always_comb begin
    f_elig   = reset && bus.f_req_valid && (!f_vld_q || bus.f_rsp_ready);
    d_elig   = reset && bus.d_req_valid && (!d_vld_q || bus.d_rsp_ready);
    grant_d  = d_elig && (!f_elig || (wait_q == MAX_W));
    grant_f  = f_elig && !grant_d;
    gnt_addr = grant_d ? bus.d_req_addr : bus.f_req_addr;
  end

  always_comb begin
    wait_d      = '0;
    last_addr_d = last_addr_q;
    f_vld_d     = f_vld_q;
    f_data_d    = f_data_q;
    f_addr_d    = f_addr_q;
    d_vld_d     = d_vld_q;
    d_data_d    = d_data_q;
    d_addr_d    = d_addr_q;

    if (d_elig && !grant_d) begin
      wait_d = (wait_q == MAX_W) ? wait_q : wait_q + 4'd1;
    end

    if (grant_f || grant_d) begin
      last_addr_d = gnt_addr;
    end

    if (grant_f) begin
      f_vld_d  = 1'b1;
      f_data_d = bus.imem_q;
      f_addr_d = bus.f_req_addr;
    end else if (f_vld_q && bus.f_rsp_ready) begin
      f_vld_d = 1'b0;
    end

    if (grant_d) begin
      d_vld_d  = 1'b1;
      d_data_d = bus.imem_q;
      d_addr_d = bus.d_req_addr;
    end else if (d_vld_q && bus.d_rsp_ready) begin
      d_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q      <= '0;
      last_addr_q <= '0;
      f_vld_q     <= 1'b0;
      f_data_q    <= '0;
      f_addr_q    <= '0;
      d_vld_q     <= 1'b0;
      d_data_q    <= '0;
      d_addr_q    <= '0;
    end else begin
      wait_q      <= wait_d;
      last_addr_q <= last_addr_d;
      f_vld_q     <= f_vld_d;
      f_data_q    <= f_data_d;
      f_addr_q    <= f_addr_d;
      d_vld_q     <= d_vld_d;
      d_data_q    <= d_data_d;
      d_addr_q    <= d_addr_d;
    end
  end

  assign bus.imem_addr   = (grant_f || grant_d) ? gnt_addr : last_addr_q;
  assign bus.f_req_ready = grant_f;
  assign bus.d_req_ready = grant_d;
  assign bus.busy        = grant_f | grant_d;
  assign bus.f_rsp_valid = f_vld_q;
  assign bus.f_rsp_data  = f_data_q;
  assign bus.f_rsp_addr  = f_addr_q;
  assign bus.d_rsp_valid = d_vld_q;
  assign bus.d_rsp_data  = d_data_q;
  assign bus.d_rsp_addr  = d_addr_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, hand-written reset/idle
// sequences and a randomized run, all checked against a per-cycle reference model.
module tb_imem_port_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int          MW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  imem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] rom [64];
  assign bus.imem_q = rom[bus.imem_addr];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: response slots, wait count and last address as plain variables
  bit          m_fv, m_dv, m_gf, m_gd, m_de;
  logic [31:0] m_fd, m_dd;
  logic [5:0]  m_fa, m_da, m_last, m_ia;
  int          m_wait;

  task automatic model_clear();
    m_fv = 0; m_dv = 0; m_fd = '0; m_dd = '0; m_fa = '0; m_da = '0;
    m_last = '0; m_wait = 0; m_gf = 0; m_gd = 0; m_de = 0;
  endtask

  task automatic model_eval();
    bit fe, de;
    fe = (reset === 1'b1) && bus.f_req_valid && (!m_fv || bus.f_rsp_ready);
    de = (reset === 1'b1) && bus.d_req_valid && (!m_dv || bus.d_rsp_ready);
    m_de = de;
    m_gf = 0; m_gd = 0;
    if (fe && de) begin
      if (m_wait == MW) m_gd = 1;
      else m_gf = 1;
    end else begin
      m_gf = fe;
      m_gd = de;
    end
    m_ia = m_gf ? bus.f_req_addr : (m_gd ? bus.d_req_addr : m_last);
  endtask

  task automatic model_update();
    if (reset !== 1'b1) begin
      model_clear();
    end else begin
      if (m_gf) begin
        m_fv = 1; m_fd = rom[bus.f_req_addr]; m_fa = bus.f_req_addr; m_last = bus.f_req_addr;
      end else if (m_fv && bus.f_rsp_ready) m_fv = 0;
      if (m_gd) begin
        m_dv = 1; m_dd = rom[bus.d_req_addr]; m_da = bus.d_req_addr; m_last = bus.d_req_addr;
      end else if (m_dv && bus.d_rsp_ready) m_dv = 0;
      if (m_gd || !m_de) m_wait = 0;
      else if (m_wait < MW) m_wait = m_wait + 1;
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_eval();
    check("model_comb", 64'({bus.f_req_ready, bus.d_req_ready, bus.busy, bus.imem_addr}),
                        64'({m_gf, m_gd, m_gf | m_gd, m_ia}));
    check("model_fslot", 64'({bus.f_rsp_valid, bus.f_rsp_addr, bus.f_rsp_data}),
                         64'({m_fv, m_fa, m_fd}));
    check("model_dslot", 64'({bus.d_rsp_valid, bus.d_rsp_addr, bus.d_rsp_data}),
                         64'({m_dv, m_da, m_dd}));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input int fv, input int fa, input int frr,
                       input int dv, input int da, input int drr);
    bus.f_req_valid = (fv != 0); bus.f_req_addr = 6'(fa); bus.f_rsp_ready = (frr != 0);
    bus.d_req_valid = (dv != 0); bus.d_req_addr = 6'(da); bus.d_rsp_ready = (drr != 0);
  endtask

  typedef struct {
    bit fv; logic [5:0] fa; bit frr; bit dv; logic [5:0] da; bit drr;
    bit e_fr; bit e_dr; logic [5:0] e_ia;
    bit e_fv; logic [31:0] e_fd; logic [5:0] e_fa;
    bit e_dv; logic [31:0] e_dd; logic [5:0] e_da;
  } vec_t;

  function automatic vec_t mk(input int fv, input int fa, input int frr,
                              input int dv, input int da, input int drr,
                              input int efr, input int edr, input int eia,
                              input int efv, input logic [31:0] efd, input int efa,
                              input int edv, input logic [31:0] edd, input int eda);
    vec_t v;
    v.fv = (fv != 0); v.fa = 6'(fa); v.frr = (frr != 0);
    v.dv = (dv != 0); v.da = 6'(da); v.drr = (drr != 0);
    v.e_fr = (efr != 0); v.e_dr = (edr != 0); v.e_ia = 6'(eia);
    v.e_fv = (efv != 0); v.e_fd = efd; v.e_fa = 6'(efa);
    v.e_dv = (edv != 0); v.e_dd = edd; v.e_da = 6'(eda);
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE0000 | 32'(i);
    rom[0]  = 32'hF8000001; rom[1]  = 32'hF8008002; rom[2]  = 32'hF8000203;
    rom[3]  = 32'h8B050083; rom[4]  = 32'hF8018003; rom[46] = 32'hB400001F;
    rom[47] = 32'h00000000; rom[63] = 32'h00000000;

    // streaming, starvation, backpressure, debug-alone-while-fetch-stalled
    tbl[0]  = mk(1,0,1, 0,0,1,   1,0,0,   0,32'h0,0,          0,32'h0,0);
    tbl[1]  = mk(1,1,1, 0,0,1,   1,0,1,   1,32'hF8000001,0,   0,32'h0,0);
    tbl[2]  = mk(1,2,1, 0,0,1,   1,0,2,   1,32'hF8008002,1,   0,32'h0,0);
    tbl[3]  = mk(1,3,1, 0,0,1,   1,0,3,   1,32'hF8000203,2,   0,32'h0,0);
    tbl[4]  = mk(1,5,1, 1,46,1,  1,0,5,   1,32'h8B050083,3,   0,32'h0,0);
    tbl[5]  = mk(1,5,1, 1,46,1,  1,0,5,   1,32'hC0DE0005,5,   0,32'h0,0);
    tbl[6]  = mk(1,5,1, 1,46,1,  1,0,5,   1,32'hC0DE0005,5,   0,32'h0,0);
    tbl[7]  = mk(1,5,1, 1,46,1,  1,0,5,   1,32'hC0DE0005,5,   0,32'h0,0);
    tbl[8]  = mk(1,5,1, 1,46,1,  0,1,46,  1,32'hC0DE0005,5,   0,32'h0,0);
    tbl[9]  = mk(1,5,1, 0,46,1,  1,0,5,   0,32'hC0DE0005,5,   1,32'hB400001F,46);
    tbl[10] = mk(1,3,1, 0,0,1,   1,0,3,   1,32'hC0DE0005,5,   0,32'hB400001F,46);
    tbl[11] = mk(1,4,0, 0,0,1,   0,0,3,   1,32'h8B050083,3,   0,32'hB400001F,46);
    tbl[12] = mk(1,4,0, 0,0,1,   0,0,3,   1,32'h8B050083,3,   0,32'hB400001F,46);
    tbl[13] = mk(1,4,0, 0,0,1,   0,0,3,   1,32'h8B050083,3,   0,32'hB400001F,46);
    tbl[14] = mk(1,4,1, 0,0,1,   1,0,4,   1,32'h8B050083,3,   0,32'hB400001F,46);
    tbl[15] = mk(1,6,0, 1,47,1,  0,1,47,  1,32'hF8018003,4,   0,32'hB400001F,46);
    tbl[16] = mk(1,6,0, 1,63,1,  0,1,63,  1,32'hF8018003,4,   1,32'h00000000,47);
    tbl[17] = mk(0,0,0, 0,0,0,   0,0,63,  1,32'hF8018003,4,   1,32'h00000000,63);

    // Reset state, with fetch requesting so ready=0 is meaningful
    drive(1,7,1, 1,8,1);
    #1 reset = 1'b0;
    model_clear();
    half();
    check("rst_f_req_ready", 64'(bus.f_req_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_f_rsp_valid", 64'(bus.f_rsp_valid), 64'd0);
    check("rst_d_rsp_valid", 64'(bus.d_rsp_valid), 64'd0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fv, tbl[i].fa, tbl[i].frr, tbl[i].dv, tbl[i].da, tbl[i].drr);
      half();
      check($sformatf("vec%0d_ready", i), 64'({bus.f_req_ready, bus.d_req_ready}),
            64'({tbl[i].e_fr, tbl[i].e_dr}));
      check($sformatf("vec%0d_imem_addr", i), 64'(bus.imem_addr), 64'(tbl[i].e_ia));
      check($sformatf("vec%0d_f_rsp", i), 64'({bus.f_rsp_valid, bus.f_rsp_addr, bus.f_rsp_data}),
            64'({tbl[i].e_fv, tbl[i].e_fa, tbl[i].e_fd}));
      check($sformatf("vec%0d_d_rsp", i), 64'({bus.d_rsp_valid, bus.d_rsp_addr, bus.d_rsp_data}),
            64'({tbl[i].e_dv, tbl[i].e_da, tbl[i].e_dd}));
      tick();
    end

    // Async reset between edges with both slots full
    drive(0,0,0, 0,0,0);
    half();
    check("pre_rst_slots_full", 64'({bus.f_rsp_valid, bus.d_rsp_valid}), 64'b11);
    #1 reset = 1'b0;
    #1;
    model_clear();
    check("arst_rsp_valid", 64'({bus.f_rsp_valid, bus.d_rsp_valid}), 64'd0);
    check("arst_f_rsp_data", 64'(bus.f_rsp_data), 64'd0);
    check("arst_rsp_addr", 64'({bus.f_rsp_addr, bus.d_rsp_addr}), 64'd0);
    check("arst_imem_addr", 64'(bus.imem_addr), 64'd0);
    tick();
    drive(1,1,1, 0,0,1);
    half();
    check("arst_hold_ready", 64'({bus.f_req_ready, bus.busy}), 64'd0);
    tick();
    reset = 1'b1;
    half();
    check("post_rst_grant", 64'({bus.f_req_ready, bus.imem_addr}), 64'({1'b1, 6'd1}));
    tick();
    drive(0,0,1, 0,0,1);
    half();
    check("post_rst_rsp", 64'({bus.f_rsp_valid, bus.f_rsp_data}), 64'({1'b1, 32'hF8008002}));
    tick();

    // Idle hold after a grant to addr 9
    drive(1,9,1, 0,0,1);
    half();
    tick();
    drive(0,0,1, 0,0,1);
    for (int i = 0; i < 5; i++) begin
      half();
      check($sformatf("idle%0d_imem_addr", i), 64'(bus.imem_addr), 64'd9);
      check($sformatf("idle%0d_busy", i), 64'(bus.busy), 64'd0);
      check($sformatf("idle%0d_rsp_valid", i), 64'({bus.f_rsp_valid, bus.d_rsp_valid}),
            64'({(i == 0), 1'b0}));
      tick();
    end

    // Randomized traffic; addresses only change after a handshake or while idle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        model_clear();
      end else begin
        reset = 1'b1;
      end
      if (!bus.f_req_valid || m_gf) begin
        bus.f_req_valid = ($urandom_range(0, 3) != 0);
        bus.f_req_addr  = 6'($urandom_range(0, 63));
      end
      if (!bus.d_req_valid || m_gd) begin
        bus.d_req_valid = ($urandom_range(0, 2) == 0);
        bus.d_req_addr  = 6'($urandom_range(0, 63));
      end
      bus.f_rsp_ready = ($urandom_range(0, 4) != 0);
      bus.d_rsp_ready = ($urandom_range(0, 2) != 0);
      half();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single combinational read port of the 64-word instruction ROM (`imem`) between two requesters: the CPU fetch port (`f_*`) and the debug/readback port (`d_*`).
- Each port uses a valid/ready request handshake and has a registered response slot with backpressure.
- Fetch has priority. A starvation counter forces a debug grant after `MAX_WAIT` consecutive lost cycles.
- Sits between the fetch stage, the debug unit and `imem`.

Parameters:
- `AW`, 6: address width; ROM depth is 2^`AW` words.
- `DW`, 32: instruction word width.
- `MAX_WAIT`, 4: consecutive cycles debug may lose arbitration before it gets forced priority; range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req_valid` in 1: fetch request valid.
- `f_req_addr` in `AW`: fetch word address.
- `f_req_ready` out 1: fetch request accepted this cycle.
- `f_rsp_valid` out 1: fetch response slot full.
- `f_rsp_data` out `DW`: fetched instruction.
- `f_rsp_addr` out `AW`: address of the word held in `f_rsp_data`.
- `f_rsp_ready` in 1: fetch consumer takes the response.
- `d_req_valid`, `d_req_addr`, `d_req_ready`, `d_rsp_valid`, `d_rsp_data`, `d_rsp_addr`, `d_rsp_ready`: same as the fetch set, for the debug port.
- `imem_addr` out `AW`: to `imem.addr`.
- `imem_q` in `DW`: from `imem.q` (combinational ROM output).
- `busy` out 1: a grant was issued this cycle.

Behaviour:
- Reset (`reset`=0, asynchronous): every register clears immediately, independent of `clk`.
  - Response signals: `f_rsp_valid`=`d_rsp_valid`=0, `*_rsp_data`=0, `*_rsp_addr`=0.
  - Internal state: wait counter=0, last-address register=0.
  - Combinational outputs during reset: `imem_addr`=0, `*_req_ready`=0, `busy`=0.
- Eligibility: port X is eligible when `X_req_valid` && (!`X_rsp_valid` || `X_rsp_ready`). A full slot being drained in the same cycle counts as free.
- Grant is combinational, at most one port per cycle:
  - only one port eligible -> that port;
  - both eligible and wait counter == `MAX_WAIT` -> debug;
  - both eligible otherwise -> fetch.
- `X_req_ready` = grant_X. `busy` = grant_f | grant_d.
- `imem_addr`:
  - granted port's address in the grant cycle;
  - otherwise the last-address register, which captures the granted address on each grant.
- Latency is 1 cycle. On the edge ending a grant cycle, for the granted port:
  - `X_rsp_data` <= `imem_q`;
  - `X_rsp_addr` <= granted addr;
  - `X_rsp_valid` <= 1.
- Drain: if `X_rsp_valid` && `X_rsp_ready` and X is not granted that cycle, then `X_rsp_valid` <= 0. Data and addr hold their last values.
- Simultaneous drain and grant on the same port: the slot is overwritten with the new word and `X_rsp_valid` stays 1. This gives 1 word/cycle throughput.
- Stall: while `X_rsp_valid`=1 and `X_rsp_ready`=0, port X is ineligible.
  - Its `req_ready`=0 and the response slot holds stable.
  - The other port arbitrates alone.
- Wait counter:
  - increments (saturating at `MAX_WAIT`) when debug is eligible but not granted;
  - clears to 0 when debug is granted, or when debug is not eligible.
- Starvation bound: with fetch continuously eligible, debug is granted on the (`MAX_WAIT`+1)th eligible cycle.
- Address wrap: `AW`-bit addresses. All 2^`AW` locations are valid; there is no out-of-range case.
- Reset mid-transaction: pending responses are discarded, slots clear, and the counter restarts at 0. Requesters must re-issue.
- Request inputs are unconstrained when `X_req_valid`=0. The requester may change addr only after a handshake or while valid=0.

Test Plan:
- Reset then fetch streaming: `f_req_valid`=1 with addr 0,1,2,3 on consecutive cycles, `f_rsp_ready`=1.
  - `f_req_ready`=1 each cycle.
  - `f_rsp_data` = f8000001, f8008002, f8000203, 8b050083 on cycles 1..4, with `f_rsp_addr` matching.
- Starvation: fetch continuously requests addr 5; debug requests addr 46; `MAX_WAIT`=4.
  - `d_req_ready`=0 for 4 cycles, then 1 on the 5th with `imem_addr`=46.
  - Next cycle `d_rsp_data`=b400001f; fetch stalls exactly that one cycle.
- Backpressure: fetch takes addr 3, then `f_rsp_ready`=0 for 3 cycles while `f_req_valid`=1 at addr 4.
  - `f_req_ready`=0 throughout; `f_rsp_data` holds 8b050083.
  - After `f_rsp_ready`=1, addr 4 is granted the same cycle; `f_rsp_data`=f8018003 the next cycle.
- Debug alone while fetch is stalled: `f_rsp_valid`=1, `f_rsp_ready`=0; debug reads addr 47 and addr 63.
  - Debug granted back-to-back; responses 00000000, 00000000.
  - Wait counter stays 0.
- Async reset mid-operation: assert `reset`=0 between clock edges while both slots are full.
  - `f_rsp_valid`, `d_rsp_valid`, `*_rsp_data` and `imem_addr` go to 0 immediately.
  - After release, a fetch of addr 1 returns f8008002 after 1 cycle.
- Idle hold: no requests for 5 cycles after a grant to addr 9.
  - `imem_addr` stays 9, `busy`=0, both `rsp_valid` drain to 0 once `rsp_ready`=1.
